// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: two-requester round-robin front end for a read-first simple-dual-port BRAM
module bram_port_arbiter #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ADDRESS_WIDTH = 11,
    parameter int unsigned INIT_CLEAR    = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     a_req_valid,
    output logic                     a_req_ready,
    input  logic                     a_req_wen,
    input  logic [ADDRESS_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0]    a_req_wdata,
    output logic                     a_resp_valid,
    output logic [DATA_WIDTH-1:0]    a_resp_rdata,
    input  logic                     b_req_valid,
    output logic                     b_req_ready,
    input  logic                     b_req_wen,
    input  logic [ADDRESS_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0]    b_req_wdata,
    output logic                     b_resp_valid,
    output logic [DATA_WIDTH-1:0]    b_resp_rdata,
    output logic [ADDRESS_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0]    mem_dout,
    output logic                     mem_wen,
    output logic [ADDRESS_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0]    mem_din,
    output logic                     busy
);
    typedef enum logic {CLEAR, RUN} state_t;
    state_t state, state_next;
    logic [ADDRESS_WIDTH-1:0] cnt, raddr_q;
    logic wptr, rptr, resp_vld, resp_own;
    logic run, clearing, aw, bw, ar, br, a_wg, b_wg, a_rg, b_rg;
    assign run      = state == RUN && !reset;
    assign clearing = state == CLEAR && !reset;
    assign aw = a_req_valid && a_req_wen;
    assign bw = b_req_valid && b_req_wen;
    assign ar = a_req_valid && !a_req_wen;
    assign br = b_req_valid && !b_req_wen;
    assign a_wg = run && aw && (!bw || !wptr);
    assign b_wg = run && bw && (!aw || wptr);
    assign a_rg = run && ar && (!br || !rptr);
    assign b_rg = run && br && (!ar || rptr);
    assign a_req_ready  = a_wg || a_rg;
    assign b_req_ready  = b_wg || b_rg;
    assign mem_wen      = clearing || a_wg || b_wg;
    assign mem_waddr    = clearing ? cnt : a_wg ? a_req_addr : b_req_addr;
    assign mem_din      = clearing ? '0 : a_wg ? a_req_wdata : b_req_wdata;
    assign mem_raddr    = reset ? '0 : a_rg ? a_req_addr : b_rg ? b_req_addr : raddr_q;
    assign busy         = reset ? INIT_CLEAR != 0 : state == CLEAR;
    assign a_resp_valid = !reset && resp_vld && !resp_own;
    assign b_resp_valid = !reset && resp_vld && resp_own;
    assign a_resp_rdata = mem_dout;
    assign b_resp_rdata = mem_dout;
    // leave the sweep once the last address has been zeroed
    always_comb begin
        state_next = state;
        if (state == CLEAR && &cnt) state_next = RUN;
    end
    // state, sweep counter and last-driven read address
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= INIT_CLEAR != 0 ? CLEAR : RUN;
            cnt     <= '0;
            raddr_q <= '0;
        end else begin
            state   <= state_next;
            cnt     <= state == CLEAR ? cnt + 1'b1 : '0;
            raddr_q <= mem_raddr;
        end
    end
    // priority pointers flip only on a conflict, pointing at the loser
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr <= 1'b0;
            rptr <= 1'b0;
        end else begin
            if (run && aw && bw) wptr <= !wptr;
            if (run && ar && br) rptr <= !rptr;
        end
    end
    // response owner tag lines up with the BRAM's one-cycle read latency
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_vld <= 1'b0;
            resp_own <= 1'b0;
        end else begin
            resp_vld <= a_rg || b_rg;
            resp_own <= b_rg;
        end
    end
endmodule
